issue_scoreboard: RTL

Single-entry issue stage placed between the operand-field mux and execute. It holds one decoded instruction (type, src1, src2, dest, cond, imm) and tracks outstanding register writes in a 32-bit busy scoreboard. It stalls the held instruction on RAW or WAW hazards and releases it downstream through a valid/ready handshake. Writeback clears busy bits; a flush drops the held instruction.

---
 rtl/eyearch_pkg.sv | 25 ++
 rtl/issue_scoreboard_operand_use.sv | 59 +++++
 rtl/issue_scoreboard.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/eyearch_pkg.sv
// Shared issue-path types: instruction class encoding, issue-stage state, register-file geometry.
// No logic and no latency.
// No backpressure; types and constants only.
package eyearch_pkg;

    // Register-file geometry shared by decode, issue and forwarding
    localparam int REG_W    = 5;
    localparam int NUM_REGS = 32;

    // Decoded instruction class
    typedef enum logic [1:0] {
        TYPE_NOP = 2'b00,
        TYPE_S   = 2'b01,
        TYPE_I   = 2'b10,
        TYPE_B   = 2'b11
    } inst_type_t;

    // Issue-stage occupancy as seen from outside
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        READY = 2'b01,
        STALL = 2'b10
    } issue_state_t;

endpackage

// File: rtl/issue_scoreboard_operand_use.sv
// Decodes an instruction class plus its register fields into read/write port usage.
// Purely combinational, zero latency.
// No backpressure; register 0 never reports as used, so it can never cause a hazard.
module operand_use #(
    parameter int REG_W = eyearch_pkg::REG_W
) (
    input  logic [1:0]       inst_type,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic [REG_W-1:0] dest,
    input  logic [REG_W-1:0] cond,
    output logic             rd1_en,
    output logic [REG_W-1:0] rd1_idx,
    output logic             rd2_en,
    output logic [REG_W-1:0] rd2_idx,
    output logic             wr_en,
    output logic [REG_W-1:0] wr_idx
);
    import eyearch_pkg::*;

    // Map each class onto two read ports and one write port; B reads src2 and cond, writes nothing
    always_comb begin
        rd1_en  = 1'b0;
        rd1_idx = '0;
        rd2_en  = 1'b0;
        rd2_idx = '0;
        wr_en   = 1'b0;
        wr_idx  = '0;
        case (inst_type_t'(inst_type))
            TYPE_S: begin
                rd1_en  = 1'b1;
                rd1_idx = src1;
                rd2_en  = 1'b1;
                rd2_idx = src2;
                wr_en   = 1'b1;
                wr_idx  = dest;
            end
            TYPE_I: begin
                rd1_en  = 1'b1;
                rd1_idx = src1;
                wr_en   = 1'b1;
                wr_idx  = dest;
            end
            TYPE_B: begin
                rd1_en  = 1'b1;
                rd1_idx = src2;
                rd2_en  = 1'b1;
                rd2_idx = cond;
            end
            default: begin
            end
        endcase
        // Register 0 is hardwired, so it never carries a dependency
        if (rd1_idx == '0) rd1_en = 1'b0;
        if (rd2_idx == '0) rd2_en = 1'b0;
        if (wr_idx  == '0) wr_en  = 1'b0;
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Single-entry issue stage with a register busy scoreboard; stalls the held op on RAW/WAW hazards.
// Latency: 1 cycle from accept to out_valid when hazard-free; writeback bypass releases a stall the same cycle.
// Backpressure: in_ready = ~held | fire, so a stalled or backpressured op blocks new input.
module issue_scoreboard #(
    parameter int NUM_REGS = eyearch_pkg::NUM_REGS,
    parameter int REG_W    = eyearch_pkg::REG_W,
    parameter int IMM_W    = 16,
    parameter int STALL_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    // decoded instruction in
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_type,
    input  logic [REG_W-1:0]    in_src1,
    input  logic [REG_W-1:0]    in_src2,
    input  logic [REG_W-1:0]    in_dest,
    input  logic [REG_W-1:0]    in_cond,
    input  logic [IMM_W-1:0]    in_imm,
    // held instruction out to execute
    output logic                out_valid,
    input  logic                out_ready,
    output logic [1:0]          out_type,
    output logic [REG_W-1:0]    out_src1,
    output logic [REG_W-1:0]    out_src2,
    output logic [REG_W-1:0]    out_dest,
    output logic [REG_W-1:0]    out_cond,
    output logic [IMM_W-1:0]    out_imm,
    // writeback and control
    input  logic                wb_valid,
    input  logic [REG_W-1:0]    wb_dest,
    input  logic                flush,
    // status
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [1:0]          state,
    output logic [STALL_W-1:0]  stall_cycles
);
    import eyearch_pkg::*;

    localparam logic [NUM_REGS-1:0] ONE_BIT = {{(NUM_REGS-1){1'b0}}, 1'b1};

    // Holding register
    logic               hold_valid;
    logic [1:0]         hold_type;
    logic [REG_W-1:0]   hold_src1;
    logic [REG_W-1:0]   hold_src2;
    logic [REG_W-1:0]   hold_dest;
    logic [REG_W-1:0]   hold_cond;
    logic [IMM_W-1:0]   hold_imm;

    // Operand usage of the held op
    logic               rd1_en;
    logic [REG_W-1:0]   rd1_idx;
    logic               rd2_en;
    logic [REG_W-1:0]   rd2_idx;
    logic               wr_en;
    logic [REG_W-1:0]   wr_idx;

    // Scoreboard datapath
    logic [NUM_REGS-1:0] wb_clr;
    logic [NUM_REGS-1:0] busy_eff;
    logic [NUM_REGS-1:0] issue_set;
    logic [NUM_REGS-1:0] busy_next;
    logic                hazard;
    logic                fire;
    logic                accept;
    issue_state_t        cur_state;

    operand_use #(
        .REG_W (REG_W)
    ) u_operand_use (
        .inst_type (hold_type),
        .src1      (hold_src1),
        .src2      (hold_src2),
        .dest      (hold_dest),
        .cond      (hold_cond),
        .rd1_en    (rd1_en),
        .rd1_idx   (rd1_idx),
        .rd2_en    (rd2_en),
        .rd2_idx   (rd2_idx),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx)
    );

    // Hazard check against the scoreboard with this cycle's writeback already removed
    always_comb begin
        wb_clr   = wb_valid ? (ONE_BIT << wb_dest) : '0;
        busy_eff = busy_mask & ~wb_clr;
        hazard   = (rd1_en & busy_eff[rd1_idx])
                 | (rd2_en & busy_eff[rd2_idx])
                 | (wr_en  & busy_eff[wr_idx]);
    end

    assign out_valid = hold_valid & ~hazard;
    assign fire      = out_valid & out_ready;
    assign in_ready  = ~hold_valid | fire;
    assign accept    = in_valid & in_ready;

    // Next scoreboard: writeback clears first, then the issuing op marks its destination
    always_comb begin
        issue_set    = (fire && wr_en) ? (ONE_BIT << wr_idx) : '0;
        busy_next    = (busy_mask & ~wb_clr) | issue_set;
        busy_next[0] = 1'b0;
    end

    // Visible state is decoded from the holding register and the live hazard
    always_comb begin
        if (!hold_valid) begin
            cur_state = EMPTY;
        end else if (hazard) begin
            cur_state = STALL;
        end else begin
            cur_state = READY;
        end
    end

    assign state = cur_state;

    // Holding register occupancy: flush wins, then accept, then departure
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
        end else if (flush) begin
            hold_valid <= 1'b0;
        end else if (accept) begin
            hold_valid <= 1'b1;
        end else if (fire) begin
            hold_valid <= 1'b0;
        end
    end

    // Capture instruction fields on accept; a flushed accept is dropped so fields stay put
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_type <= '0;
            hold_src1 <= '0;
            hold_src2 <= '0;
            hold_dest <= '0;
            hold_cond <= '0;
            hold_imm  <= '0;
        end else if (accept && !flush) begin
            hold_type <= in_type;
            hold_src1 <= in_src1;
            hold_src2 <= in_src2;
            hold_dest <= in_dest;
            hold_cond <= in_cond;
            hold_imm  <= in_imm;
        end
    end

    // Scoreboard survives flush because in-flight ops still write back
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_mask <= '0;
        end else begin
            busy_mask <= busy_next;
        end
    end

    // Saturating count of cycles spent stalled on a hazard
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (cur_state == STALL && stall_cycles != {STALL_W{1'b1}}) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    assign out_type = hold_type;
    assign out_src1 = hold_src1;
    assign out_src2 = hold_src2;
    assign out_dest = hold_dest;
    assign out_cond = hold_cond;
    assign out_imm  = hold_imm;

endmodule
